credit_sender: RTL and testbench

CREDIT_SENDER -- requirements
Module: credit_sender

---
 rtl/credit_pkg.sv | 15 +
 rtl/credit_counter.sv | 52 +++++
 rtl/credit_sender.sv | 121 ++++++++++++
 tb/tb_credit_sender.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// credit_pkg: shared types and helpers for the credit-based sender.
//   credit_state_e : IDLE / ACTIVE state of the sender (drives the idle output)
//   credit_width() : number of bits needed to hold a credit count 0..credits
package credit_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } credit_state_e;

   function automatic int credit_width(input int credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/credit_counter.sv
// credit_counter: saturating up/down counter holding the available credits.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, loads MAX
//   inc    : one credit returned
//   dec    : one credit consumed
//   clear  : synchronous reload to MAX, dominates inc/dec
//   count  : current credit count
//   at_max : count == MAX
module credit_counter
   import credit_pkg::*;
#(
   parameter int MAX   = 8,
   parameter int WIDTH = credit_width(MAX)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   // inc and dec together cancel. Both directions are guarded so the count
   // can never wrap, whatever the caller does.
   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = MAX_VAL;
      end else if (inc && !dec) begin
         if (count_reg != MAX_VAL) count_next = count_reg + ONE;
      end else if (dec && !inc) begin
         if (count_reg != '0) count_next = count_reg - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_reg <= MAX_VAL;
      else        count_reg <= count_next;
   end

   assign count  = count_reg;
   assign at_max = (count_reg == MAX_VAL);

endmodule

// File: rtl/credit_sender.sv
// credit_sender: forwards an upstream valid/ready stream into a remote FIFO
// write port that has no back-pressure. One credit per remote slot; a beat is
// only accepted while a credit is available (or one is returned that cycle).
// Optional feature macro: CREDIT_SENDER_ERR_CHECK_EN enables the sticky
// err_overflow flag (set when a credit returns while all credits are home);
// without it err_overflow is tied low and the counter just saturates.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush               : synchronous return to the post-reset state
//   s_data/s_valid/s_ready : upstream stream
//   m_data/m_valid      : remote FIFO write data / strobe (1 cycle latency)
//   credit_return       : one pulse per freed remote slot
//   credit_count        : credits currently available
//   idle                : all credits home and no write pending
//   err_overflow        : sticky credit overflow (macro builds only)
module credit_sender
   import credit_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CREDITS    = 8,
   parameter int CNT_WIDTH  = credit_width(CREDITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  credit_return,
   output logic [CNT_WIDTH-1:0]  credit_count,
   output logic                  idle,
   output logic                  err_overflow
);

   localparam logic [CNT_WIDTH-1:0] NEAR_MAX = CNT_WIDTH'(CREDITS - 1);

   credit_state_e         state_reg;
   logic                  idle_reg;
   logic                  m_valid_reg;
   logic [DATA_WIDTH-1:0] m_data_reg;
   logic                  at_max;
   logic                  accept;
   logic                  full_next;

   // A credit returned this cycle can be spent this cycle. Flush blocks
   // acceptance so the upstream beat is held rather than dropped.
   assign s_ready = ((credit_count != '0) | credit_return) & ~flush;
   assign accept  = s_valid & s_ready;

   credit_counter #(
      .MAX   (CREDITS),
      .WIDTH (CNT_WIDTH)
   ) u_credit_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (credit_return),
      .dec    (accept),
      .clear  (flush),
      .count  (credit_count),
      .at_max (at_max)
   );

   // Will all credits be home after this edge? Lets the FSM track idle with
   // no extra cycle of lag.
   assign full_next = flush
                    | (at_max & ~(accept & ~credit_return))
                    | ((credit_count == NEAR_MAX) & credit_return & ~accept);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         idle_reg    <= 1'b1;
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
      end else begin
         m_valid_reg <= accept;
         if (accept) m_data_reg <= s_data;

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg <= ACTIVE;
                  idle_reg  <= 1'b0;
               end
            end
            ACTIVE: begin
               // An accept this cycle means m_valid is pending next cycle.
               if (full_next && !accept) begin
                  state_reg <= IDLE;
                  idle_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               idle_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign idle    = idle_reg;

`ifdef CREDIT_SENDER_ERR_CHECK_EN
   logic err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   err_reg <= 1'b0;
      else if (flush)                               err_reg <= 1'b0;
      else if (credit_return && !accept && at_max)  err_reg <= 1'b1;
   end

   assign err_overflow = err_reg;
`else
   assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_credit_sender.sv
// tb_credit_sender: self-checking bench for credit_sender (CREDITS=4).
// Directed scenarios (fill-up, zero-credit bypass, accept+return, overflow,
// flush, mid-transfer reset) followed by randomized traffic and a remote FIFO
// model with random read-ready. A credit-level reference model computes all
// expected values.
module tb_credit_sender;

   localparam int DW      = 8;
   localparam int CREDITS = 4;
   localparam int CW      = $clog2(CREDITS + 1);
`ifdef CREDIT_SENDER_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          credit_return;
   logic [CW-1:0] credit_count;
   logic          idle;
   logic          err_overflow;

   credit_sender #(
      .DATA_WIDTH (DW),
      .CREDITS    (CREDITS)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .credit_return (credit_return),
      .credit_count  (credit_count),
      .idle          (idle),
      .err_overflow  (err_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: credits available, pending write, sticky error
   int          avail;
   bit          exp_mvalid;
   logic [DW-1:0] exp_mdata;
   bit          exp_err;
   int          acc_count;

   // remote FIFO model
   bit          remote_en;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sent_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      avail      = CREDITS;
      exp_mvalid = 1'b0;
      exp_mdata  = '0;
      exp_err    = 1'b0;
   endtask

   task automatic check_outputs(input string ctx);
      check_eq({ctx, ".credit_count"}, 32'(credit_count), 32'(avail));
      check_eq({ctx, ".m_valid"}, 32'(m_valid), 32'(exp_mvalid));
      check_eq({ctx, ".m_data"}, 32'(m_data), 32'(exp_mdata));
      check_eq({ctx, ".idle"}, 32'(idle), 32'((avail == CREDITS) && !exp_mvalid));
      check_eq({ctx, ".err_overflow"}, 32'(err_overflow), 32'(exp_err));
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit ret, input bit fl);
      bit exp_rdy;
      bit acc;
      logic [DW-1:0] popped;
      s_valid       = v;
      s_data        = d;
      credit_return = ret;
      flush         = fl;
      #1;
      exp_rdy = !fl && ((avail != 0) || ret);
      check_eq("s_ready", 32'(s_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      if (remote_en) begin
         if (ret) begin
            popped = fifo_q.pop_front();
            check_eq("fifo_order", 32'(popped), 32'(sent_q.pop_front()));
         end
         if (m_valid) begin
            check_eq("no_write_when_full", 32'(fifo_q.size() < CREDITS), 32'd1);
            fifo_q.push_back(m_data);
         end
      end
      @(posedge clk);
      #1;
      if (fl) begin
         model_reset_keep_data();
      end else begin
         if (acc && !ret)        avail--;
         else if (ret && !acc) begin
            if (avail == CREDITS) exp_err = exp_err | ERR_EN;
            else                  avail++;
         end
         exp_mvalid = acc;
         if (acc) begin
            exp_mdata = d;
            acc_count++;
            if (remote_en) sent_q.push_back(d);
            $display("beat %0d data=%02h credits=%0d", acc_count, d, avail);
         end
      end
      check_outputs("step");
   endtask

   task automatic model_reset_keep_data();
      avail      = CREDITS;
      exp_mvalid = 1'b0;
      exp_err    = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      s_valid       = 1'b1;
      s_data        = 8'h3C;
      credit_return = 1'b0;
      remote_en     = 1'b0;
      acc_count     = 0;
      model_reset();
      #12;
      // held in reset: nothing accepted, post-reset values
      check_outputs("reset");
      s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("post_release");

      // fill up: s_valid held, no returns -> exactly CREDITS beats
      acc_count = 0;
      for (int i = 0; i < CREDITS + 2; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check_eq("fill_accepts", 32'(acc_count), 32'(CREDITS));
      check_eq("fill_count_zero", 32'(credit_count), 32'd0);

      // zero credits, return pulse with s_valid -> accepted, count stays 0
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      check_eq("bypass_mvalid", 32'(m_valid), 32'd1);
      check_eq("bypass_count", 32'(credit_count), 32'd0);

      // two credits, accept + return same cycle -> stays 2
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      check_eq("acc_ret_count", 32'(credit_count), 32'd2);

      // idle + extra return -> saturates, error only with the macro
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("sat_count", 32'(credit_count), 32'(CREDITS));
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check_eq("err_sticky", 32'(err_overflow), 32'(ERR_EN));

      // flush with 3 outstanding and a beat in flight
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      check_eq("flush_count", 32'(credit_count), 32'(CREDITS));
      check_eq("flush_mvalid", 32'(m_valid), 32'd0);
      check_eq("flush_idle", 32'(idle), 32'd1);

      // reset mid-transfer: beat in flight is dropped
      step(1'b1, 8'h77, 1'b0, 1'b0);
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check_eq("no_replay_mvalid", 32'(m_valid), 32'd0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(bit'($urandom_range(0, 3) != 0), 8'($urandom),
              bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 39) == 0));
      end

      // against a remote FIFO with random read-ready
      step(1'b0, 8'h00, 1'b0, 1'b1);
      fifo_q.delete();
      sent_q.delete();
      remote_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 3) != 0), 8'($urandom),
              (fifo_q.size() != 0) && ($urandom_range(0, 2) != 0), 1'b0);
      end
      remote_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
